// File: rtl/pin_driver_if.sv
// Request/completion handshake between the FPGA core and pin_driver.
// The core side is the master; pin_driver is the slave.
interface pin_driver_if;
  logic req;
  logic din;
  logic ready;
  logic done;

  modport master (
    output req,
    output din,
    input  ready,
    input  done
  );

  modport slave (
    input  req,
    input  din,
    output ready,
    output done
  );
endinterface

// File: rtl/pin_driver.sv
// Tri-state sequencer for one bidirectional pad, timed on the shared ena strobe.
// Optional pad readback / contention detection is built when PIN_DRIVER_READBACK_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | ready, buffer off, pin_o at IDLE_LEVEL
// S_ARM     | data bit latched, waiting for the next ena tick
// S_DRIVE   | buffer on, pin_o = latched bit for HOLD_TICKS ena ticks
// S_RELEASE | buffer off for TURN_TICKS ena ticks of bus turnaround
module pin_driver #(
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned TURN_TICKS = 1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         ena_i,
  pin_driver_if.slave  bus,
  output logic         pin_o,
  output logic         pin_oe_o
`ifdef PIN_DRIVER_READBACK_EN
  ,
  input  logic         pin_i,
  output logic         contention_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_DRIVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);
  localparam logic [7:0] TURN_LOAD = 8'(TURN_TICKS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       data_q, data_d;
  logic       pin_o_q, pin_o_d;
  logic       pin_oe_q, pin_oe_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      data_q   <= IDLE_LEVEL;
      pin_o_q  <= IDLE_LEVEL;
      pin_oe_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      pin_o_q  <= pin_o_d;
      pin_oe_q <= pin_oe_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Down-counter terminates on the ena edge that takes it from 1 to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_ARM;
          data_d  = bus.din;
        end
      end
      S_ARM: begin
        if (ena_i) begin
          state_d = S_DRIVE;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_DRIVE: begin
        if (ena_i) begin
          if (cnt_q <= 8'd1) begin
            if (TURN_TICKS > 0) begin
              state_d = S_RELEASE;
              cnt_d   = TURN_LOAD;
            end else begin
              state_d = S_IDLE;
              cnt_d   = 8'd0;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_RELEASE: begin
        if (ena_i) begin
          if (cnt_q <= 8'd1) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Outputs are decoded from the next state so pin_o and pin_oe flip on the same edge.
    ready_d  = (state_d == S_IDLE);
    pin_oe_d = (state_d == S_DRIVE);
    pin_o_d  = pin_oe_d ? data_d : IDLE_LEVEL;
    done_d   = ((state_q == S_DRIVE) || (state_q == S_RELEASE)) && (state_d == S_IDLE);
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign pin_o     = pin_o_q;
  assign pin_oe_o  = pin_oe_q;

`ifdef PIN_DRIVER_READBACK_EN
  logic [1:0] rb_q;
  logic [1:0] tick_q;
  logic       contention_q;
  logic       accept;
  logic       mismatch;

  assign accept   = (state_q == S_IDLE) && bus.req;
  assign mismatch = (rb_q[0] != data_q) && (rb_q[1] != data_q);

  // tick_q saturates at 2: the readback pipe is only trusted once it has
  // refilled with samples taken while the buffer was on.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rb_q         <= {IDLE_LEVEL, IDLE_LEVEL};
      tick_q       <= 2'd0;
      contention_q <= 1'b0;
    end else begin
      if (ena_i) begin
        rb_q <= {rb_q[0], pin_i};
      end
      if (state_q != S_DRIVE) begin
        tick_q <= 2'd0;
      end else if (ena_i && (tick_q != 2'd2)) begin
        tick_q <= tick_q + 2'd1;
      end
      if (accept) begin
        contention_q <= 1'b0;
      end else if ((state_q == S_DRIVE) && ena_i && (tick_q == 2'd2) && mismatch) begin
        contention_q <= 1'b1;
      end
    end
  end

  assign contention_o = contention_q;
`endif

endmodule

// File: tb/tb_pin_driver.sv
// Directed bench for pin_driver: vector table on one instance plus
// hand-written sequences for sparse ena, back-to-back requests and readback.
module tb_pin_driver;

  logic clk;
  logic reset;
  logic ena;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pin_driver_if bus_a ();
  pin_driver_if bus_b ();
  pin_driver_if bus_c ();
  logic pin_o_a, pin_oe_a;
  logic pin_o_b, pin_oe_b;
  logic pin_o_c, pin_oe_c;

`ifdef PIN_DRIVER_READBACK_EN
  logic cont_a, cont_b, cont_c;
  pin_driver_if bus_d ();
  logic pin_o_d, pin_oe_d, pin_i_d, cont_d;
  logic rb_follow;
  always_comb pin_i_d = rb_follow ? pin_o_d : 1'b0;
`endif

  pin_driver #(.HOLD_TICKS(3), .TURN_TICKS(2), .IDLE_LEVEL(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset), .ena_i(ena), .bus(bus_a.slave),
    .pin_o(pin_o_a), .pin_oe_o(pin_oe_a)
`ifdef PIN_DRIVER_READBACK_EN
    , .pin_i(pin_o_a), .contention_o(cont_a)
`endif
  );

  pin_driver #(.HOLD_TICKS(2), .TURN_TICKS(1), .IDLE_LEVEL(1'b1)) dut_b (
    .clk_i(clk), .reset_i(reset), .ena_i(ena), .bus(bus_b.slave),
    .pin_o(pin_o_b), .pin_oe_o(pin_oe_b)
`ifdef PIN_DRIVER_READBACK_EN
    , .pin_i(pin_o_b), .contention_o(cont_b)
`endif
  );

  pin_driver #(.HOLD_TICKS(1), .TURN_TICKS(0), .IDLE_LEVEL(1'b1)) dut_c (
    .clk_i(clk), .reset_i(reset), .ena_i(ena), .bus(bus_c.slave),
    .pin_o(pin_o_c), .pin_oe_o(pin_oe_c)
`ifdef PIN_DRIVER_READBACK_EN
    , .pin_i(pin_o_c), .contention_o(cont_c)
`endif
  );

`ifdef PIN_DRIVER_READBACK_EN
  pin_driver #(.HOLD_TICKS(4), .TURN_TICKS(1), .IDLE_LEVEL(1'b1)) dut_d (
    .clk_i(clk), .reset_i(reset), .ena_i(ena), .bus(bus_d.slave),
    .pin_o(pin_o_d), .pin_oe_o(pin_oe_d),
    .pin_i(pin_i_d), .contention_o(cont_d)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // in = {reset, ena, req, din}; exp = {ready, pin_oe, pin_o, done}
  typedef struct packed {
    logic [3:0] in;
    logic [3:0] exp;
  } vec_t;

  vec_t tv [24];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int rise_i, fall_i, done_i, done_cnt, bad_o;
    logic prev_oe;
    logic got_done;
    logic any_cont;

    reset = 1'b1;
    ena   = 1'b0;
    bus_a.req = 1'b0; bus_a.din = 1'b0;
    bus_b.req = 1'b0; bus_b.din = 1'b0;
    bus_c.req = 1'b0; bus_c.din = 1'b0;
`ifdef PIN_DRIVER_READBACK_EN
    bus_d.req = 1'b0; bus_d.din = 1'b0;
    rb_follow = 1'b0;
`endif

    // dut_a: HOLD=3, TURN=2
    tv[0]  = '{4'b1100, 4'b1010};  // reset
    tv[1]  = '{4'b0110, 4'b0010};  // accept din=0 -> ARM
    tv[2]  = '{4'b0111, 4'b0100};  // DRIVE, req/din ignored
    tv[3]  = '{4'b0111, 4'b0100};
    tv[4]  = '{4'b0101, 4'b0100};
    tv[5]  = '{4'b0101, 4'b0010};  // RELEASE after E1+3
    tv[6]  = '{4'b0111, 4'b0010};  // req ignored in RELEASE
    tv[7]  = '{4'b0101, 4'b1011};  // IDLE, done
    tv[8]  = '{4'b0101, 4'b1010};
    tv[9]  = '{4'b0011, 4'b0010};  // accept din=1 with ena=0
    tv[10] = '{4'b0001, 4'b0010};  // ARM waits for ena
    tv[11] = '{4'b0100, 4'b0110};  // DRIVE pin_o=1
    tv[12] = '{4'b0000, 4'b0110};
    tv[13] = '{4'b0100, 4'b0110};
    tv[14] = '{4'b0100, 4'b0110};
    tv[15] = '{4'b0010, 4'b0110};
    tv[16] = '{4'b0100, 4'b0010};  // third drive tick -> RELEASE
    tv[17] = '{4'b0100, 4'b0010};
    tv[18] = '{4'b0000, 4'b0010};
    tv[19] = '{4'b0100, 4'b1011};  // IDLE, done
    tv[20] = '{4'b0010, 4'b0010};  // req in done cycle accepted
    tv[21] = '{4'b0100, 4'b0100};  // DRIVE pin_o=0
    tv[22] = '{4'b1100, 4'b1010};  // reset mid-drive
    tv[23] = '{4'b0100, 4'b1010};  // no done after reset

    for (int i = 0; i < 24; i++) begin
      {reset, ena, bus_a.req, bus_a.din} = tv[i].in;
      step();
      check($sformatf("vec%0d", i),
            32'({bus_a.ready, pin_oe_a, pin_o_a, bus_a.done}), 32'(tv[i].exp));
    end
    bus_a.req = 1'b0;

    // dut_b: HOLD=2, TURN=1, ena every 4th cycle
    reset = 1'b1; ena = 1'b0; step();
    reset = 1'b0;
    rise_i = -1; fall_i = -1; done_i = -1; done_cnt = 0; bad_o = 0;
    prev_oe = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ena = ((i % 4) == 3);
      bus_b.req = (i == 1);
      bus_b.din = 1'b1;
      step();
      if (pin_oe_b && !prev_oe) rise_i = i;
      if (!pin_oe_b && prev_oe) fall_i = i;
      if (bus_b.done) begin done_cnt++; done_i = i; end
      if (pin_o_b !== 1'b1) bad_o++;
      prev_oe = pin_oe_b;
    end
    bus_b.req = 1'b0;
    check("sparse_rise", 32'(rise_i), 32'd3);
    check("sparse_width", 32'(fall_i - rise_i), 32'd8);
    check("sparse_done_at", 32'(done_i), 32'd15);
    check("sparse_done_cnt", 32'(done_cnt), 32'd1);
    check("sparse_pin_o_stable", 32'(bad_o), 32'd0);

    // dut_c: HOLD=1, TURN=0, back-to-back request in the done cycle
    ena = 1'b1;
    bus_c.req = 1'b1; bus_c.din = 1'b0; step();
    check("b2b_arm1", 32'({bus_c.ready, pin_oe_c, bus_c.done}), 32'b000);
    bus_c.req = 1'b0; step();
    check("b2b_drive1", 32'({pin_oe_c, pin_o_c}), 32'b10);
    step();
    check("b2b_done1", 32'({bus_c.ready, pin_oe_c, bus_c.done}), 32'b101);
    bus_c.req = 1'b1; bus_c.din = 1'b1; step();
    check("b2b_arm2", 32'({bus_c.ready, pin_oe_c, bus_c.done}), 32'b000);
    bus_c.req = 1'b0; step();
    check("b2b_drive2", 32'({pin_oe_c, pin_o_c}), 32'b11);
    step();
    check("b2b_done2", 32'({bus_c.ready, pin_oe_c, bus_c.done}), 32'b101);
    step();
    check("b2b_idle", 32'({bus_c.ready, pin_oe_c, bus_c.done}), 32'b100);

`ifdef PIN_DRIVER_READBACK_EN
    // dut_d: HOLD=4, pad stuck low while driving 1
    reset = 1'b1; step();
    reset = 1'b0;
    check("rb_reset", 32'(cont_d), 32'd0);
    bus_d.req = 1'b1; bus_d.din = 1'b1; step();
    bus_d.req = 1'b0; step();
    step();
    step();
    check("rb_tick2", 32'(cont_d), 32'd0);
    step();
    check("rb_tick3", 32'(cont_d), 32'd1);
    got_done = 1'b0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      step();
      got_done = bus_d.done;
    end
    check("rb_done_seen", 32'(got_done), 32'd1);
    check("rb_sticky", 32'(cont_d), 32'd1);
    step();
    rb_follow = 1'b1;
    bus_d.req = 1'b1; bus_d.din = 1'b0; step();
    bus_d.req = 1'b0;
    check("rb_clear", 32'(cont_d), 32'd0);
    any_cont = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any_cont = any_cont | cont_d;
      got_done = got_done | bus_d.done;
    end
    check("rb_follow_done", 32'(got_done), 32'd1);
    check("rb_follow_clean", 32'(any_cont), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
